phys_mem_ctrl: RTL and testbench

- Physical memory controller; the responder for the MMU's device-memory interface (dev_mem_*).
- Drives one asynchronous 32-bit-wide SRAM.
- Reads are zero-wait: combinational, answered before the next posedge.
- Writes are multi-cycle: address and data are latched, busy is held until the SRAM write cycle completes. Sits between the MMU and the board SRAM pins.

---
 rtl/phys_mem_pkg.sv | 22 ++
 rtl/phys_mem_ctrl.sv | 79 +++++++
 tb/tb_phys_mem_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/phys_mem_pkg.sv
// Shared physical-memory constants: FSM encoding, RAM base and the in-range predicate
// reused by device decode.
`ifndef PHYS_MEM_PKG_SV
`define PHYS_MEM_PKG_SV

// True when a byte address falls inside a 2^aw-word RAM at PHYS_RAM_BASE.
`define PHYS_IN_RANGE(addr, aw) ((((addr) - phys_mem_pkg::PHYS_RAM_BASE) >> ((aw) + 2)) == 32'h0)

package phys_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_W_SETUP = 2'd1,
      ST_W_PULSE = 2'd2,
      ST_W_HOLD  = 2'd3
   } state_t;

   localparam logic [31:0] PHYS_RAM_BASE = 32'h0;

endpackage

`endif

// File: rtl/phys_mem_ctrl.sv
// Device-memory responder for the MMU: zero-wait reads and multi-cycle latched writes
// to one asynchronous 32-bit SRAM.
module phys_mem_ctrl
   import phys_mem_pkg::*;
#(
   parameter int ADDR_WIDTH = 20,
   parameter int WE_PULSE   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           mem_addr,
   input  logic [31:0]           mem_data_in,
   input  logic                  mem_is_write,
   output logic [31:0]           mem_data_out,
   output logic                  mem_busy,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   input  logic [31:0]           sram_dq_in,
   output logic [31:0]           sram_dq_out,
   output logic                  sram_dq_oe,
   output logic                  sram_ce_n,
   output logic                  sram_oe_n,
   output logic                  sram_we_n
);

   localparam int CNT_W = (WE_PULSE > 1) ? $clog2(WE_PULSE) : 1;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_addr_lat;
   logic [31:0]           r_data_lat;
   logic                  r_in_range_lat;
   logic [CNT_W-1:0]      r_cnt;

   logic                  w_in_range;
   logic                  w_idle;

   assign w_in_range = `PHYS_IN_RANGE(mem_addr, ADDR_WIDTH);
   assign w_idle     = (r_state == ST_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= ST_IDLE;
         r_addr_lat     <= '0;
         r_data_lat     <= '0;
         r_in_range_lat <= 1'b0;
         r_cnt          <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (mem_is_write) begin
                  r_addr_lat     <= mem_addr[ADDR_WIDTH+1:2];
                  r_data_lat     <= mem_data_in;
                  r_in_range_lat <= w_in_range;
                  r_state        <= ST_W_SETUP;
               end
            end
            ST_W_SETUP: begin
               r_cnt   <= CNT_W'(WE_PULSE - 1);
               r_state <= ST_W_PULSE;
            end
            ST_W_PULSE: begin
               if (r_cnt == '0) r_state <= ST_W_HOLD;
               else             r_cnt   <= r_cnt - 1'b1;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Strobes decode from registered state only so mem_is_write can never glitch the pins.
   assign sram_ce_n    = 1'b0;
   assign sram_oe_n    = !w_idle;
   assign sram_we_n    = !((r_state == ST_W_PULSE) && r_in_range_lat);
   assign sram_dq_oe   = !w_idle;
   assign sram_dq_out  = r_data_lat;
   assign sram_addr    = w_idle ? mem_addr[ADDR_WIDTH+1:2] : r_addr_lat;
   assign mem_busy     = !w_idle || mem_is_write;
   assign mem_data_out = (w_idle && w_in_range) ? sram_dq_in : 32'h0;

endmodule

// File: tb/tb_phys_mem_ctrl.sv
// Directed bench for phys_mem_ctrl with a small behavioural SRAM model.
module tb_phys_mem_ctrl;
   localparam int AW = 20;
   localparam int WP = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [31:0]   mem_addr, mem_data_in, mem_data_out;
   logic          mem_is_write, mem_busy;
   logic [AW-1:0] sram_addr;
   logic [31:0]   sram_dq_in, sram_dq_out;
   logic          sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

   int n_tests = 0;
   int n_fail  = 0;
   int n_overlap = 0;

   logic [31:0] ram [0:1023];
   logic        pl_en;
   logic [9:0]  pl_a;
   logic [31:0] pl_d;

   always #5 clk = ~clk;

   phys_mem_ctrl #(.ADDR_WIDTH(AW), .WE_PULSE(WP)) dut (
      .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
      .mem_is_write(mem_is_write), .mem_data_out(mem_data_out), .mem_busy(mem_busy),
      .sram_addr(sram_addr), .sram_dq_in(sram_dq_in), .sram_dq_out(sram_dq_out),
      .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
      .sram_we_n(sram_we_n));

   assign sram_dq_in = ram[sram_addr[9:0]];

   // SRAM model: a word is stored on every clock edge the write strobe is low.
   always @(posedge clk) begin
      if (pl_en) ram[pl_a] <= pl_d;
      else if (!sram_we_n && !sram_ce_n && sram_dq_oe) ram[sram_addr[9:0]] <= sram_dq_out;
      if (!sram_we_n && !sram_oe_n) n_overlap <= n_overlap + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic preload(input logic [9:0] a, input logic [31:0] d);
      pl_en = 1'b1; pl_a = a; pl_d = d;
      @(posedge clk); #1;
      pl_en = 1'b0;
   endtask

   // Issues a write (caller sits just after a posedge); scrambles mem_* while busy and
   // returns just after the posedge that enters IDLE, with mem_addr back on addr.
   task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                           input logic exp_we);
      int nb = 0, nwe = 0, noe = 0;
      mem_addr = addr; mem_data_in = data; mem_is_write = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         nb  += int'(mem_busy);
         nwe += int'(!sram_we_n);
         noe += int'(sram_dq_oe);
         if (i == 2) begin
            chk({tag, ".addr"}, 32'(sram_addr), 32'(addr[AW+1:2]));
            chk({tag, ".dq"}, sram_dq_out, data);
         end
         @(posedge clk); #1;
         if (i == 0) begin
            mem_is_write = 1'b0; mem_addr = 32'h100; mem_data_in = 32'h0;
         end
         if (i == 4) mem_addr = addr;
      end
      chk({tag, ".busy_cyc"}, 32'(nb), 32'(WP + 3));
      chk({tag, ".we_cyc"}, 32'(nwe), exp_we ? 32'(WP) : 32'h0);
      chk({tag, ".oe_cyc"}, 32'(noe), 32'(WP + 2));
   endtask

   initial begin
      rst = 1'b1; mem_addr = 32'h0; mem_data_in = 32'h0; mem_is_write = 1'b0;
      pl_en = 1'b0; pl_a = '0; pl_d = '0;
      repeat (2) @(posedge clk); #1;
      preload(10'h10, 32'hDEADBEEF);
      preload(10'h40, 32'hCAFE0040);
      preload(10'h00, 32'h11111111);
      preload(10'h20, 32'h0);
      @(negedge clk);
      chk("rst.we_n", 32'(sram_we_n), 32'h1);
      chk("rst.oe_n", 32'(sram_oe_n), 32'h0);
      chk("rst.ce_n", 32'(sram_ce_n), 32'h0);
      chk("rst.dq_oe", 32'(sram_dq_oe), 32'h0);
      chk("rst.busy", 32'(mem_busy), 32'h0);
      mem_is_write = 1'b1; #1;
      chk("rst.busy_wr", 32'(mem_busy), 32'h1);
      @(posedge clk); #1;   // still in reset: write must not be accepted
      rst = 1'b0; mem_is_write = 1'b0;
      @(negedge clk);
      chk("rstwr.dq_oe", 32'(sram_dq_oe), 32'h0);
      chk("rstwr.busy", 32'(mem_busy), 32'h0);

      // Zero-wait read
      mem_addr = 32'h40;
      @(negedge clk);
      chk("rd.addr", 32'(sram_addr), 32'h10);
      chk("rd.data", mem_data_out, 32'hDEADBEEF);
      chk("rd.busy", 32'(mem_busy), 32'h0);
      @(posedge clk); #1;

      // Single write with latch check
      do_write("wr1", 32'h80, 32'h12345678, 1'b1);
      @(negedge clk);
      chk("wr1.idle_busy", 32'(mem_busy), 32'h0);
      chk("wr1.readback", mem_data_out, 32'h12345678);
      chk("wr1.model", ram[10'h20], 32'h12345678);
      mem_addr = 32'h100;
      @(negedge clk);
      chk("wr1.untouched", mem_data_out, 32'hCAFE0040);
      @(posedge clk); #1;

      // Out-of-range read and write
      mem_addr = 32'h0040_0000;
      @(negedge clk);
      chk("oor.rd", mem_data_out, 32'h0);
      @(posedge clk); #1;
      do_write("oor", 32'h0040_0000, 32'hAAAA5555, 1'b0);
      mem_addr = 32'h0;
      @(negedge clk);
      chk("oor.word0", mem_data_out, 32'h11111111);
      chk("oor.word40", ram[10'h40], 32'hCAFE0040);
      @(posedge clk); #1;

      // Reset during the first W_PULSE cycle
      mem_addr = 32'h300; mem_data_in = 32'h55AA55AA; mem_is_write = 1'b1;
      @(posedge clk); #1;
      mem_is_write = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("rstmid.pulse", 32'(sram_we_n), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rstmid.we_n", 32'(sram_we_n), 32'h1);
      chk("rstmid.dq_oe", 32'(sram_dq_oe), 32'h0);
      chk("rstmid.busy", 32'(mem_busy), 32'h0);
      @(posedge clk); #1;

      // Back-to-back writes: second issued in the first IDLE cycle
      do_write("b2b0", 32'h200, 32'h0BADF00D, 1'b1);
      do_write("b2b1", 32'h204, 32'hFEEDFACE, 1'b1);
      mem_addr = 32'h200;
      @(negedge clk);
      chk("b2b.rd0", mem_data_out, 32'h0BADF00D);
      mem_addr = 32'h204;
      @(negedge clk);
      chk("b2b.rd1", mem_data_out, 32'hFEEDFACE);
      chk("overlap", 32'(n_overlap), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
